// File: rtl/prbs_test_ctrl.sv
// -----------------------------------------------------------------------------
// prbs_test_ctrl
//
// Sequencer for one pattern/PRBS test on an external datapath. A start request
// in IDLE captures the configuration into shadow registers, restarts the
// datapath for one cycle (LOAD), then enables it (RUN) until the pattern
// detector reports dp_valid, a timeout expires, or the test is aborted. After
// dp_valid the datapath stays enabled for PRBS_CYC further cycles (PRBS), then
// a one-cycle DONE state publishes the result.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset, overrides every other input
//   start        single-cycle request to run one test (honoured only in IDLE)
//   abort        terminates a running test (LOAD/RUN/PRBS)
//   cfg_n        pattern repeat count; 0 is rejected as a bad configuration
//   cfg_pattern  pattern word
//   cfg_timeout  RUN cycles allowed beyond the first before giving up
//   dp_enable    registered datapath enable, high in RUN and PRBS only
//   dp_n         shadowed repeat count to the datapath
//   dp_pattern   shadowed pattern word to the datapath
//   dp_valid     pattern-detector valid from the datapath
//   busy         high in LOAD, RUN and PRBS
//   done         one-cycle completion pulse (DONE state)
//   pass         result of the last test
//   err_code     00 ok, 01 bad config, 10 timeout, 11 abort
//   byte_cnt     enabled RUN cycles before dp_valid (saturating)
// pass/err_code/byte_cnt change only when entering DONE and are cleared when
// a test is accepted.
// -----------------------------------------------------------------------------
module prbs_test_ctrl #(
   parameter int PATT_WIDTH = 8,
   parameter int PATT_NUM   = 4,
   parameter int REPEAT_W   = 5,
   parameter int TMO_W      = 8,
   parameter int PRBS_CYC   = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             abort,
   input  logic [REPEAT_W-1:0]              cfg_n,
   input  logic [PATT_WIDTH*PATT_NUM-1:0]   cfg_pattern,
   input  logic [TMO_W-1:0]                 cfg_timeout,
   output logic                             dp_enable,
   output logic [REPEAT_W-1:0]              dp_n,
   output logic [PATT_WIDTH*PATT_NUM-1:0]   dp_pattern,
   input  logic                             dp_valid,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic [1:0]                       err_code,
   output logic [15:0]                      byte_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_PRBS,
      S_DONE
   } state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_CFG   = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   // PRBS_CYC is limited to 1..255, so an 8-bit phase counter always suffices.
   localparam logic [7:0] PRBS_LAST = 8'(PRBS_CYC - 1);

   state_t             state;
   logic [TMO_W-1:0]   sh_timeout;
   logic [TMO_W-1:0]   timer;
   logic [15:0]        run_cnt;
   logic [7:0]         prbs_cnt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // All outputs are registered and set on the transition into the state that
   // owns them, so every output reflects the current state with no decode.
   // NOTE: state is updated with non-blocking assignments only; a blocking
   // assignment here would let later statements see the new value in the same
   // edge and break the register-per-state timing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         dp_enable  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_code   <= ERR_OK;
         byte_cnt   <= '0;
         dp_n       <= '0;
         dp_pattern <= '0;
         sh_timeout <= '0;
         timer      <= '0;
         run_cnt    <= '0;
         prbs_cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_n != '0) begin
                     state      <= S_LOAD;
                     busy       <= 1'b1;
                     dp_n       <= cfg_n;
                     dp_pattern <= cfg_pattern;
                     sh_timeout <= cfg_timeout;
                     pass       <= 1'b0;
                     err_code   <= ERR_OK;
                     byte_cnt   <= '0;
                     timer      <= '0;
                     run_cnt    <= '0;
                  end else begin
                     // Rejected request: shadows keep the previous test's values.
                     state    <= S_DONE;
                     done     <= 1'b1;
                     pass     <= 1'b0;
                     err_code <= ERR_CFG;
                     byte_cnt <= '0;
                  end
               end
            end

            S_LOAD: begin
               if (abort) begin
                  state    <= S_DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  pass     <= 1'b0;
                  err_code <= ERR_ABORT;
                  byte_cnt <= run_cnt;
               end else begin
                  state     <= S_RUN;
                  dp_enable <= 1'b1;
               end
            end

            S_RUN: begin
               // Priority: abort, then dp_valid, then timeout.
               if (abort) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  dp_enable <= 1'b0;
                  pass      <= 1'b0;
                  err_code  <= ERR_ABORT;
                  byte_cnt  <= run_cnt;
               end else if (dp_valid) begin
                  // run_cnt freezes here: the valid cycle itself is not counted.
                  state    <= S_PRBS;
                  prbs_cnt <= '0;
               end else if (timer == sh_timeout) begin
                  // The expiring cycle was an enabled cycle without valid, so
                  // it is included in the published count.
                  state     <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  dp_enable <= 1'b0;
                  pass      <= 1'b0;
                  err_code  <= ERR_TMO;
                  run_cnt   <= sat_inc(run_cnt);
                  byte_cnt  <= sat_inc(run_cnt);
               end else begin
                  run_cnt <= sat_inc(run_cnt);
                  timer   <= timer + 1'b1;
               end
            end

            S_PRBS: begin
               if (abort) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  dp_enable <= 1'b0;
                  pass      <= 1'b0;
                  err_code  <= ERR_ABORT;
                  byte_cnt  <= run_cnt;
               end else if (prbs_cnt == PRBS_LAST) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  dp_enable <= 1'b0;
                  pass      <= 1'b1;
                  err_code  <= ERR_OK;
                  byte_cnt  <= run_cnt;
               end else begin
                  prbs_cnt <= prbs_cnt + 8'd1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               dp_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prbs_test_ctrl
//
// Each test is described as a scenario (config, RUN cycle of dp_valid, cycle
// of abort). A scenario-level model turns that into the cycle at which DONE
// occurs and the published result; from those the expected value of every
// output in every cycle follows directly. A single negedge process compares
// the DUT against those expectations. Directed scenarios pin the model with
// hand-computed literal results; randomized scenarios follow.
// Cycle c of a test: c=0 is the cycle start is driven, c=1 is LOAD, RUN cycle
// r is c=1+r.
// -----------------------------------------------------------------------------
module tb_prbs_test_ctrl;

   localparam int PW       = 32;
   localparam int RW       = 5;
   localparam int TW       = 8;
   localparam int PRBS_CYC = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [RW-1:0] cfg_n = '0;
   logic [PW-1:0] cfg_pattern = '0;
   logic [TW-1:0] cfg_timeout = '0;
   logic          dp_valid = 1'b0;
   logic          dp_enable, busy, done, pass;
   logic [RW-1:0] dp_n;
   logic [PW-1:0] dp_pattern;
   logic [1:0]    err_code;
   logic [15:0]   byte_cnt;

   always #5 clk = ~clk;

   prbs_test_ctrl #(
      .PATT_WIDTH(8), .PATT_NUM(4), .REPEAT_W(RW), .TMO_W(TW), .PRBS_CYC(PRBS_CYC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_n(cfg_n), .cfg_pattern(cfg_pattern), .cfg_timeout(cfg_timeout),
      .dp_enable(dp_enable), .dp_n(dp_n), .dp_pattern(dp_pattern),
      .dp_valid(dp_valid), .busy(busy), .done(done), .pass(pass),
      .err_code(err_code), .byte_cnt(byte_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- expectations written by the driver ----------------
   bit            exp_on = 1'b0;
   logic          exp_en, exp_busy, exp_done, exp_pass;
   logic [1:0]    exp_err;
   logic [15:0]   exp_bytes;
   logic [RW-1:0] exp_n;
   logic [PW-1:0] exp_pat;

   // held results and shadows as the model sees them
   logic          h_pass  = 1'b0;
   logic [1:0]    h_err   = 2'b00;
   logic [15:0]   h_bytes = '0;
   logic [RW-1:0] h_n     = '0;
   logic [PW-1:0] h_pat   = '0;

   // ---------------- observation counters ----------------
   int          en_total   = 0;
   int          done_total = 0;
   logic        obs_pass;
   logic [1:0]  obs_err;
   logic [15:0] obs_bytes;

   always @(negedge clk) begin
      if (exp_on) begin
         check("dp_enable",  dp_enable,  exp_en);
         check("busy",       busy,       exp_busy);
         check("done",       done,       exp_done);
         check("pass",       pass,       exp_pass);
         check("err_code",   err_code,   exp_err);
         check("byte_cnt",   byte_cnt,   exp_bytes);
         check("dp_n",       dp_n,       exp_n);
         check("dp_pattern", dp_pattern, exp_pat);
      end
      if (dp_enable === 1'b1) en_total++;
      if (done === 1'b1) begin
         done_total++;
         obs_pass  = pass;
         obs_err   = err_code;
         obs_bytes = byte_cnt;
      end
   end

   // ---------------- scenario model ----------------
   typedef struct {
      int unsigned   n;
      logic [PW-1:0] pat;
      int unsigned   tmo;
      int unsigned   v;   // RUN cycle (1-based) carrying dp_valid, 0 = never
      int unsigned   a;   // test cycle carrying abort, 0 = none
   } scen_t;

   function automatic scen_t mk(int unsigned n, logic [PW-1:0] pat, int unsigned tmo,
                                int unsigned v, int unsigned a);
      scen_t s;
      s.n = n; s.pat = pat; s.tmo = tmo; s.v = v; s.a = a;
      return s;
   endfunction

   // Returns the DONE cycle, the published result and the last RUN index.
   function automatic void predict(input scen_t s, output int unsigned c_done,
                                   output logic p, output logic [1:0] e,
                                   output int unsigned bytes, output int unsigned r_end);
      bit          via_valid;
      int unsigned nat_done;
      if (s.n == 0) begin
         c_done = 1; p = 1'b0; e = 2'b01; bytes = 0; r_end = 0;
         return;
      end
      via_valid = (s.v != 0) && (s.v <= s.tmo + 1);
      r_end     = via_valid ? s.v : s.tmo + 1;
      nat_done  = via_valid ? 2 + s.v + PRBS_CYC : s.tmo + 3;
      if (s.a >= 1 && s.a < nat_done) begin
         c_done = s.a + 1;
         p      = 1'b0;
         e      = 2'b11;
         if (s.a <= 1)              bytes = 0;          // LOAD
         else if (s.a <= 1 + r_end) bytes = s.a - 2;    // RUN: cycles before abort
         else                       bytes = s.v - 1;    // PRBS
      end else begin
         c_done = nat_done;
         p      = via_valid;
         e      = via_valid ? 2'b00 : 2'b10;
         bytes  = via_valid ? s.v - 1 : s.tmo + 1;
      end
   endfunction

   task automatic set_exp(input logic en, input logic bsy, input logic dn);
      exp_en    = en;
      exp_busy  = bsy;
      exp_done  = dn;
      exp_pass  = h_pass;
      exp_err   = h_err;
      exp_bytes = h_bytes;
      exp_n     = h_n;
      exp_pat   = h_pat;
   endtask

   task automatic randomize_cfg();
      cfg_n       = RW'($urandom);
      cfg_pattern = $urandom;
      cfg_timeout = TW'($urandom);
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      start    = 1'b0;
      abort    = ($urandom_range(3) == 0);
      dp_valid = $urandom_range(1);
      randomize_cfg();
      set_exp(1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_test(input scen_t s, input int gap, output int en_cyc, output int dones);
      int unsigned c_done, fb, r_end;
      logic        fp;
      logic [1:0]  fe;
      int          en0, d0;
      en0 = en_total;
      d0  = done_total;
      predict(s, c_done, fp, fe, fb, r_end);
      for (int unsigned c = 0; c <= c_done; c++) begin
         @(posedge clk); #1;
         start = (c == 0) || (c == 3) || ($urandom_range(7) == 0);
         abort = ((s.a != 0) && (c == s.a)) ||
                 (((c == 0) || (c == c_done)) && ($urandom_range(3) == 0));
         if (c == 0) begin
            cfg_n       = RW'(s.n);
            cfg_pattern = s.pat;
            cfg_timeout = TW'(s.tmo);
         end else begin
            randomize_cfg();
         end
         dp_valid = ((s.v != 0) && (c == 1 + s.v)) ||
                    (((c <= 1) || (c > 1 + r_end)) && ($urandom_range(1) == 1));
         if (c == 1 && s.n != 0) begin
            h_pass = 1'b0; h_err = 2'b00; h_bytes = '0;
            h_n = RW'(s.n); h_pat = s.pat;
         end
         if (c == c_done) begin
            h_pass = fp; h_err = fe; h_bytes = 16'(fb);
         end
         set_exp((s.n != 0) && (c >= 2) && (c < c_done),
                 (s.n != 0) && (c >= 1) && (c < c_done),
                 (c == c_done));
      end
      repeat (gap) idle_cycle();
      en_cyc = en_total - en0;
      dones  = done_total - d0;
   endtask

   task automatic run_reset_test();
      int d0;
      d0 = done_total;
      for (int c = 0; c <= 6; c++) begin
         @(posedge clk); #1;
         randomize_cfg();
         dp_valid = 1'b0;
         start    = (c == 0) || (c == 5);
         abort    = (c == 5);
         rst      = (c == 5);
         if (c == 0) begin
            cfg_n = 5'd4; cfg_pattern = 32'h1234_5678; cfg_timeout = 8'd30;
         end
         if (c == 1) begin
            h_pass = 1'b0; h_err = 2'b00; h_bytes = '0; h_n = 5'd4; h_pat = 32'h1234_5678;
         end
         if (c == 6) begin
            h_pass = 1'b0; h_err = 2'b00; h_bytes = '0; h_n = '0; h_pat = '0;
         end
         set_exp((c >= 2) && (c <= 5), (c >= 1) && (c <= 5), 1'b0);
      end
      idle_cycle();
      check("rst_no_done", done_total - d0, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int    en_c, d_c;
      scen_t s;
      int unsigned nd, fb, re;
      logic        fp;
      logic [1:0]  fe;

      @(posedge clk); #1;
      set_exp(1'b0, 1'b0, 1'b0);
      exp_on = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0);
      check("reset_byte_cnt", byte_cnt, 0);
      check("reset_dp_pattern", dp_pattern, 0);

      // valid on the 12th RUN cycle
      run_test(mk(3, 32'hA5C3_0F1E, 50, 12, 0), 2, en_c, d_c);
      check("basic_byte_cnt", obs_bytes, 11);
      check("basic_pass", obs_pass, 1);
      check("basic_err", obs_err, 2'b00);
      check("basic_en_cycles", en_c, 28);
      check("basic_done_pulses", d_c, 1);

      // bad config
      run_test(mk(0, 32'hDEAD_BEEF, 9, 3, 0), 1, en_c, d_c);
      check("badcfg_err", obs_err, 2'b01);
      check("badcfg_pass", obs_pass, 0);
      check("badcfg_en_cycles", en_c, 0);
      check("badcfg_done_pulses", d_c, 1);

      // timeout 5, never valid
      run_test(mk(7, 32'h0BAD_F00D, 5, 0, 0), 1, en_c, d_c);
      check("tmo_en_cycles", en_c, 6);
      check("tmo_err", obs_err, 2'b10);
      check("tmo_byte_cnt", obs_bytes, 6);
      check("tmo_pass", obs_pass, 0);

      // abort in 3rd PRBS cycle (valid at RUN 4 -> PRBS cycles 6,7,8)
      run_test(mk(2, 32'h5555_AAAA, 50, 4, 8), 1, en_c, d_c);
      check("abort_prbs_err", obs_err, 2'b11);
      check("abort_prbs_en_cycles", en_c, 7);
      check("abort_prbs_byte_cnt", obs_bytes, 3);
      check("abort_prbs_done_pulses", d_c, 1);

      // dp_valid and abort in the same RUN cycle
      run_test(mk(5, 32'h0F0F_F0F0, 40, 7, 8), 1, en_c, d_c);
      check("abort_valid_err", obs_err, 2'b11);
      check("abort_valid_byte_cnt", obs_bytes, 6);

      // timeout 0: one RUN cycle
      run_test(mk(1, 32'h0000_0001, 0, 0, 0), 1, en_c, d_c);
      check("tmo0_en_cycles", en_c, 1);
      check("tmo0_byte_cnt", obs_bytes, 1);

      // valid on the very cycle the timer expires: valid wins
      run_test(mk(9, 32'hCAFE_0001, 3, 4, 0), 1, en_c, d_c);
      check("valid_at_tmo_pass", obs_pass, 1);
      check("valid_at_tmo_byte_cnt", obs_bytes, 3);
      check("valid_at_tmo_en_cycles", en_c, 20);

      // abort in LOAD
      run_test(mk(4, 32'h1357_9BDF, 20, 5, 1), 1, en_c, d_c);
      check("abort_load_err", obs_err, 2'b11);
      check("abort_load_en_cycles", en_c, 0);

      // maximum timeout
      run_test(mk(31, 32'hFFFF_FFFF, 255, 0, 0), 1, en_c, d_c);
      check("tmo_max_byte_cnt", obs_bytes, 256);
      check("tmo_max_en_cycles", en_c, 256);

      // reset mid-RUN, then a fresh test
      run_reset_test();
      run_test(mk(3, 32'hA5C3_0F1E, 50, 12, 0), 1, en_c, d_c);
      check("post_rst_pass", obs_pass, 1);
      check("post_rst_byte_cnt", obs_bytes, 11);

      // randomized scenarios
      for (int i = 0; i < 120; i++) begin
         s = mk(($urandom_range(7) == 0) ? 0 : $urandom_range(1, 31),
                $urandom, $urandom_range(0, 40),
                ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 45), 0);
         predict(s, nd, fp, fe, fb, re);
         if ($urandom_range(2) == 0) s.a = $urandom_range(1, nd);
         run_test(s, $urandom_range(1, 3), en_c, d_c);
         check("rand_done_pulses", d_c, 1);
      end

      exp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
